// File: rtl/control_unit.sv
// Hardwired control sequencer for the DataPath: fetch in T0-T2, then per-opcode
// execute steps, one control step per clock, all strobes Moore-decoded from state and opcode.
module control_unit #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zlowout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Csignout,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        run,
    output logic        illegal,
    output logic [3:0]  step
);

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd14,
        RST  = 4'd15
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state;
    state_t     next_state;
    logic [4:0] opcode;
    logic       is_addr;
    logic       is_mem;
    logic       is_reg;
    logic       is_imm;
    logic       is_nop;
    logic       is_halt;
    logic       ir_fields_unused;

    // Register fields are decoded inside the DataPath via Gra/Grb/Grc.
    assign opcode           = IR[31:27];
    assign ir_fields_unused = ^IR[26:0];

    assign is_mem  = (opcode == OP_LD) || (opcode == OP_ST);
    assign is_addr = is_mem || (opcode == OP_LDI);
    assign is_reg  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
    assign is_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_nop  = (opcode == OP_NOP);
    assign is_halt = (opcode == OP_HALT);

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= RST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RST:  next_state = T0;
            T0:   next_state = T1;
            T1:   next_state = T2;
            T2:   next_state = T3;
            T3: begin
                if (is_addr || is_reg || is_imm) begin
                    next_state = T4;
                end else if (is_nop) begin
                    next_state = T0;
                end else if (is_halt) begin
                    next_state = HALT;
                end else begin
                    next_state = HALT_ON_ILLEGAL ? HALT : T0;
                end
            end
            T4:   next_state = T5;
            T5:   next_state = is_mem ? T6 : T0;
            T6:   next_state = T7;
            T7:   next_state = T0;
            HALT: next_state = HALT;
            default: next_state = RST;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowin   = 1'b0;
        Zlowout  = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        BAout    = 1'b0;
        Csignout = 1'b0;
        ADD      = 1'b0;
        SUB      = 1'b0;
        AND      = 1'b0;
        OR       = 1'b0;
        run      = 1'b1;
        illegal  = 1'b0;
        step     = state;

        // clear overrides the whole decode in the same cycle it is seen
        if (clear) begin
            step = 4'd15;
        end else begin
            case (state)
                T0: begin
                    PCout  = 1'b1;
                    MARin  = 1'b1;
                    IncPC  = 1'b1;
                    Zlowin = 1'b1;
                end
                T1: begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                    Read    = 1'b1;
                    MDRin   = 1'b1;
                end
                T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                T3: begin
                    if (is_addr) begin
                        Grb   = 1'b1;
                        BAout = 1'b1;
                        Yin   = 1'b1;
                    end else if (is_reg || is_imm) begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end else if (!is_nop && !is_halt) begin
                        illegal = 1'b1;
                    end
                end
                T4: begin
                    Zlowin   = 1'b1;
                    Grc      = is_reg;
                    Rout     = is_reg;
                    Csignout = !is_reg;
                    ADD      = is_addr || (opcode == OP_ADD) || (opcode == OP_ADDI);
                    SUB      = (opcode == OP_SUB);
                    AND      = (opcode == OP_AND) || (opcode == OP_ANDI);
                    OR       = (opcode == OP_OR) || (opcode == OP_ORI);
                end
                T5: begin
                    Zlowout = 1'b1;
                    if (is_mem) begin
                        MARin = 1'b1;
                    end else begin
                        Gra = 1'b1;
                        Rin = 1'b1;
                    end
                end
                T6: begin
                    MDRin = 1'b1;
                    if (opcode == OP_ST) begin
                        Gra  = 1'b1;
                        Rout = 1'b1;
                    end else begin
                        Read = 1'b1;
                    end
                end
                T7: begin
                    if (opcode == OP_ST) begin
                        Write = 1'b1;
                    end else begin
                        MDRout = 1'b1;
                        Gra    = 1'b1;
                        Rin    = 1'b1;
                    end
                end
                HALT: run = 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer sitting directly upstream of `DataPath`: it reads the instruction register and drives every datapath strobe (bus-out selects, register loads, ALU op, memory read/write), one control step per clock. It executes the fetch sequence T0–T2, then the per-opcode execute steps. It replaces hand-driven testbench stimulus for the supported instruction subset.

## Interface
- `HALT_ON_ILLEGAL`, default 0: 1 means an unsupported opcode enters HALT; 0 means it executes as `nop` (retires after T3).
- `clock`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  reset. Synchronous and active-high.
- `IR`  in  32  instruction register contents from `DataPath`. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0].
- Strobe outputs, each 1 bit:
  - `PCout`, `PCin`, `IncPC`
  - `MARin`, `MDRin`, `MDRout`, `Read`, `Write`
  - `IRin`, `Yin`, `Zlowin`, `Zlowout`
  - `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`, `Csignout`
  - `ADD`, `SUB`, `AND`, `OR`
- `run`  out  1  1 while executing; 0 in HALT.
- `illegal`  out  1  one-cycle pulse in T3 of an unsupported opcode.
- `step`  out  4  current step number (RST=15, T0..T7=0..7, HALT=14), for debug.

## Operation
- States: RST, T0–T7, HALT.
- All strobes are Moore-decoded from the state register and the opcode `IR[31:27]`.
- Each state lasts exactly one clock. The datapath captures on the edge that ends the step.

Fetch (all opcodes):
- T0: `PCout MARin IncPC Zlowin`
- T1: `Zlowout PCin Read MDRin`
- T2: `MDRout IRin`
- `IR` becomes valid at the T2→T3 edge. Decode is combinational in T3 onward, and `IR` stays stable until the next T2.

Opcodes and execute steps:
- ldi 00001:
  - T3 `Grb BAout Yin`
  - T4 `Csignout ADD Zlowin`
  - T5 `Zlowout Gra Rin`
  - then T0.
- ld 00000: same T3/T4 as ldi, then:
  - T5 `Zlowout MARin`
  - T6 `Read MDRin`
  - T7 `MDRout Gra Rin`
  - then T0.
- st 00010: same T3/T4 as ldi, then:
  - T5 `Zlowout MARin`
  - T6 `Gra Rout MDRin` (`Read`=0, so MDR takes the bus)
  - T7 `Write`
  - then T0.
- add/sub/and/or (00011/00100/00101/00110):
  - T3 `Grb Rout Yin`
  - T4 `Grc Rout <op> Zlowin`
  - T5 `Zlowout Gra Rin`
  - then T0.
- addi/andi/ori (01100/01101/01110):
  - T3 `Grb Rout Yin`
  - T4 `Csignout <ADD|AND|OR> Zlowin`
  - T5 `Zlowout Gra Rin`
  - then T0.
- nop 11010: T3 drives no strobes, then T0.
- halt 11011: T3 drives no strobes, then HALT. HALT holds all strobes 0 and `run`=0 until `clear`.
- Any other opcode: `illegal`=1 in T3, no other strobes.
  - Next state is T0 when `HALT_ON_ILLEGAL`=0, HALT when it is 1.
- Exactly one ALU op strobe is high in any T4 that asserts `Zlowin`, except T0, where `IncPC` alone drives the increment.

## Timing
- Reset:
  - During any cycle with `clear`=1, all strobes and `illegal` are forced to 0, `run`=1, `step`=15.
  - The edge with `clear`=1 loads RST.
  - RST drives no strobes and always advances to T0 on the next edge.
  - `clear` mid-instruction aborts it. No partial step is completed after the aborting edge.
- Cycles per instruction, counted T0 through the last step:
  - ldi/ALU/imm: 6
  - ld/st: 8
  - nop/illegal (non-halting): 4
- The first T0 follows `clear` deassertion by 1 cycle (the RST cycle).
- `Read` and `Write` are never high in the same cycle.
- `Rin` and `Rout` are never high in the same cycle.
- At most one bus driver is high per cycle: `PCout`, `Zlowout`, `MDRout`, `Rout`, `BAout`, `Csignout`.

## Test plan
- Reset, then `IR`=0x08800005 (ldi R1,5(R0)):
  - `step` sequence 15,0,1,2,3,4,5,0.
  - T3 shows `Grb BAout Yin`.
  - T5 shows `Zlowout Gra Rin`.
  - T1 shows `Read`=1.
- `IR`=0x01000095 (ld R2,0x95(R0)):
  - 8-cycle sequence.
  - T6 `Read MDRin`, T7 `MDRout Gra Rin`.
  - `Write` stays 0 throughout.
- `IR`=0x10800090 (st 0x90(R0),R1):
  - T6 `Gra Rout MDRin` with `Read`=0.
  - T7 `Write`=1 only.
- `IR`=0x19890000 (add R3,R1,R2):
  - T4 `Grc Rout ADD Zlowin`; `SUB`/`AND`/`OR` stay 0.
  - Repeat for sub/and/or/addi/andi/ori, checking the op strobe for each.
- `IR`=0xF8000000 (illegal opcode):
  - `HALT_ON_ILLEGAL`=0: `illegal` pulses in T3, next step 0.
  - `HALT_ON_ILLEGAL`=1: `step`=14, `run`=0.
- Edge cases:
  - `IR`=0xD8000000 (halt): HALT holds `run`=0 and all strobes 0 for 10+ cycles.
  - `clear` asserted in HALT: RST then T0.
  - `clear` asserted in T6 of ld: next edge `step`=15 with no `MDRout`/`Rin` pulse, then T0.
